edge_sampled_reg: RTL

Parametrised successor to the single-bit async-clear D-type cell. A WIDTH-bit register, clocked only by MasterClock, that treats the emulated chip clock `clk` as data. It synchronises `clk`, detects the selected edge(s), and loads `d` with setup-accurate alignment. Used wherever a gate-level flop bank on a derived clock must live in the single MasterClock domain.

---
 rtl/edge_reg_pkg.sv | 21 ++
 rtl/edge_sampled_reg_if.sv | 24 ++
 rtl/edge_sync_shift.sv | 31 +++
 rtl/edge_sampled_reg.sv | 115 +++++++++++
 4 files changed

// File: rtl/edge_reg_pkg.sv
// Shared types and helpers for the edge-sampled register family.
package edge_reg_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE,
    EDGE_FALL,
    EDGE_BOTH
  } edge_mode_t;

  typedef enum logic {
    FILL,
    RUN
  } fill_state_t;

  // Pipeline index holding the d/en sample that pairs with a detected edge.
  function automatic int unsigned tap_index(input int unsigned stages,
                                            input int unsigned data_tap);
    return stages - 1 + data_tap;
  endfunction

endpackage

// File: rtl/edge_sampled_reg_if.sv
// Data/control bundle of an edge-sampled register: emulated clock, data in, registered outputs.
interface edge_sampled_reg_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             clk;
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qL;
  logic             strobe;
  logic             armed;

  modport master (
    output clk, d, en,
    input  q, qL, strobe, armed
  );

  modport slave (
    input  clk, d, en,
    output q, qL, strobe, armed
  );

endinterface

// File: rtl/edge_sync_shift.sv
// Synchroniser/history shift register for a clock sampled as data; flags rise and fall
// once the new level has reached the last-but-one stage.
module edge_sync_shift #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES:0] h_q;
  logic [STAGES:0] h_d;

  always_comb begin
    h_d = {h_q[STAGES-1:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
    end else begin
      h_q <= h_d;
    end
  end

  assign rise_c = h_q[STAGES-1] & ~h_q[STAGES];
  assign fall_c = ~h_q[STAGES-1] & h_q[STAGES];

endmodule

// File: rtl/edge_sampled_reg.sv
// WIDTH-bit register in the MasterClock domain that loads d on selected edges of an
// emulated clock, with d/en delayed to line up with the synchronised edge.
module edge_sampled_reg
  import edge_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter edge_mode_t       EDGE_MODE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      DATA_TAP    = 1
) (
  input  logic                MasterClock,
  input  logic                rL,
  edge_sampled_reg_if.slave   bus
);

  localparam int unsigned TAP   = tap_index(SYNC_STAGES, DATA_TAP);
  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);

  localparam logic [0:0] ST_FILL = 1'(FILL);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  // Stages beyond the tap are never observed, so the pipelines stop there.
  logic [TAP:0][WIDTH-1:0] dp_q, dp_d;
  logic [TAP:0]            ep_q, ep_d;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ql_q, ql_d;
  logic             strobe_q, strobe_d;

  logic rise_c;
  logic fall_c;
  logic fire_c;

  edge_sync_shift #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (MasterClock),
    .rst_n  (rL),
    .din    (bus.clk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    case (EDGE_MODE)
      EDGE_FALL: fire_c = fall_c;
      EDGE_BOTH: fire_c = rise_c | fall_c;
      default:   fire_c = rise_c;
    endcase
  end

  // Next-state: pipelines, fill sequencing and the output load.
  always_comb begin
    dp_d     = {dp_q[TAP-1:0], bus.d};
    ep_d     = {ep_q[TAP-1:0], bus.en};
    state_d  = state_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    q_d      = q_q;
    strobe_d = 1'b0;

    case (state_q)
      ST_FILL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SYNC_STAGES)) begin
          state_d = ST_RUN;
          armed_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (fire_c && ep_q[TAP]) begin
          q_d      = dp_q[TAP];
          strobe_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    ql_d = ~q_d;
  end

  always_ff @(posedge MasterClock or negedge rL) begin
    if (!rL) begin
      dp_q     <= '0;
      ep_q     <= '0;
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      q_q      <= RESET_VALUE;
      ql_q     <= ~RESET_VALUE;
      strobe_q <= 1'b0;
    end else begin
      dp_q     <= dp_d;
      ep_q     <= ep_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      q_q      <= q_d;
      ql_q     <= ql_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.qL     = ql_q;
  assign bus.strobe = strobe_q;
  assign bus.armed  = armed_q;

endmodule
